// File: rtl/cfg_read_pkg.sv
// Shared types and constants for the configuration-bit readback block.
package cfg_read_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam state_e RST_STATE   = IDLE;
    localparam logic   RST_BUSY    = 1'b0;
    localparam logic   RST_VALID   = 1'b0;
    localparam logic   RST_LAST    = 1'b0;
    localparam logic   RST_CHANGED = 1'b0;

    // Tile index width; a single-tile fabric still needs a 1-bit index port.
    function automatic int tile_w(input int num_tiles);
        return (num_tiles <= 2) ? 1 : $clog2(num_tiles);
    endfunction

endpackage

// File: rtl/cfg_sync_chain.sv
// Free-running multi-bit synchroniser; each bit passes through STAGES flops.
module cfg_sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/config_bit_reader.sv
// Snapshots the synchronised per-tile config bits on request and streams one word per
// tile over valid/ready, flagging words that differ from the last completed sweep.
//   state | meaning
//   IDLE  | waiting for start; no word offered
//   SEND  | offering snapshot word idx; advance on handshake, finish after last tile
module config_bit_reader
    import cfg_read_pkg::*;
#(
    parameter  int NUM_BITS    = 12,
    parameter  int NUM_TILES   = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int TILE_W      = tile_w(NUM_TILES)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_TILES*NUM_BITS-1:0] C_bits,
    input  logic                          start,
    output logic                          busy,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [NUM_BITS-1:0]           rd_data,
    output logic [TILE_W-1:0]             rd_tile,
    output logic                          rd_last,
    output logic                          rd_changed
);

    localparam int                 VEC_W    = NUM_TILES * NUM_BITS;
    localparam logic [TILE_W-1:0]  LAST_IDX = TILE_W'(NUM_TILES - 1);

    logic [VEC_W-1:0]    sync_q;
    state_e              state_q, state_d;
    logic [TILE_W-1:0]   idx_q, idx_d;
    logic [VEC_W-1:0]    snap_q, snap_d;
    logic [VEC_W-1:0]    prev_q, prev_d;
    logic [NUM_BITS-1:0] cur_word;
    logic [NUM_BITS-1:0] prev_word;
    logic                last_w;

    cfg_sync_chain #(
        .WIDTH  (VEC_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (C_bits),
        .q_o   (sync_q)
    );

    assign cur_word  = snap_q[int'(idx_q)*NUM_BITS +: NUM_BITS];
    assign prev_word = prev_q[int'(idx_q)*NUM_BITS +: NUM_BITS];
    assign last_w    = (idx_q == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RST_STATE;
            idx_q   <= '0;
            snap_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            prev_q  <= prev_d;
        end
    end

    // start is only looked at in IDLE, so a request during a sweep is simply dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        prev_d  = prev_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = sync_q;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rd_ready) begin
                    if (last_w) begin
                        prev_d  = snap_q;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + TILE_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy       = RST_BUSY;
        rd_valid   = RST_VALID;
        rd_data    = '0;
        rd_tile    = '0;
        rd_last    = RST_LAST;
        rd_changed = RST_CHANGED;
        if (state_q == SEND) begin
            busy       = 1'b1;
            rd_valid   = 1'b1;
            rd_data    = cur_word;
            rd_tile    = idx_q;
            rd_last    = last_w;
            rd_changed = (cur_word != prev_word);
        end
    end

endmodule

// File: tb/tb_config_bit_reader.sv
// Bench for config_bit_reader: directed sweeps compared against expected-word tables,
// plus randomized traffic checked against a sweep-level reference model.
module tb_config_bit_reader;

    localparam int NB = 12;
    localparam int NT = 4;
    localparam int W  = NB * NT;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  C_bits = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [NB-1:0] rd_data;
    logic [1:0]    rd_tile;
    logic          rd_last;
    logic          rd_changed;

    config_bit_reader dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_bits     (C_bits),
        .start      (start),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_tile    (rd_tile),
        .rd_last    (rd_last),
        .rd_changed (rd_changed)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]    tile;
        logic [NB-1:0] data;
        logic          changed;
        logic          last;
    } word_t;

    int n_cmp = 0;
    int n_err = 0;

    word_t         exp_q[$];
    word_t         got[$];
    word_t         exp_tab [NT];
    logic [NB-1:0] m_snap [NT];
    logic [NB-1:0] m_prev [NT];
    logic [W-1:0]  h0 = '0, h1 = '0, h2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The synchronised value seen at an edge is what was driven two cycles earlier.
    task automatic cycle(input logic rst_v, input logic start_v, input logic ready_v,
                         input logic [W-1:0] cb);
        word_t w;
        @(negedge CLK);
        RST = rst_v; start = start_v; rd_ready = ready_v; C_bits = cb;
        h2 = h1; h1 = h0; h0 = cb;
        #1;
        if (exp_q.size() > 0) begin
            chk("valid", 32'(rd_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("tile", 32'(rd_tile), 32'(exp_q[0].tile));
            chk("data", 32'(rd_data), 32'(exp_q[0].data));
            chk("last", 32'(rd_last), 32'(exp_q[0].last));
            chk("changed", 32'(rd_changed), 32'(exp_q[0].changed));
        end else begin
            chk("idle_valid", 32'(rd_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        if (rst_v) begin
            exp_q.delete();
            for (int t = 0; t < NT; t++) m_prev[t] = '0;
            h0 = '0; h1 = '0;
        end else if (exp_q.size() > 0) begin
            if (ready_v) begin
                got.push_back('{tile: rd_tile, data: rd_data, changed: rd_changed, last: rd_last});
                if (exp_q[0].last)
                    for (int t = 0; t < NT; t++) m_prev[t] = m_snap[t];
                void'(exp_q.pop_front());
            end
        end else if (start_v) begin
            for (int t = 0; t < NT; t++) begin
                w.tile    = 2'(t);
                w.data    = h2[t*NB +: NB];
                w.changed = (w.data != m_prev[t]);
                w.last    = (t == NT - 1);
                m_snap[t] = w.data;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic set_tab(input logic [W-1:0] cb, input logic [NT-1:0] chg);
        for (int t = 0; t < NT; t++)
            exp_tab[t] = '{tile: 2'(t), data: cb[t*NB +: NB], changed: chg[t], last: (t == NT - 1)};
    endtask

    task automatic check_got(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(NT));
        for (int t = 0; t < NT && t < got.size(); t++) begin
            chk({name, "_tile"}, 32'(got[t].tile), 32'(exp_tab[t].tile));
            chk({name, "_data"}, 32'(got[t].data), 32'(exp_tab[t].data));
            chk({name, "_last"}, 32'(got[t].last), 32'(exp_tab[t].last));
            chk({name, "_changed"}, 32'(got[t].changed), 32'(exp_tab[t].changed));
        end
        got.delete();
    endtask

    task automatic sweep(input logic [W-1:0] cb);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, cb);
        cycle(0, 1, 1, cb);
        for (int i = 0; i < NT; i++) cycle(0, 0, 1, cb);
        cycle(0, 0, 1, cb);
    endtask

    logic [W-1:0] cb1, cb2, cb3, cb4, cbr;

    initial begin
        for (int t = 0; t < NT; t++) begin m_prev[t] = '0; m_snap[t] = '0; end
        cb1 = {12'h123, 12'hFFF, 12'h000, 12'hA5A};
        cb2 = {12'h123, 12'hFFE, 12'h000, 12'hA5A};
        cb4 = {12'h0F0, 12'h001, 12'h000, 12'hA5A};

        cycle(1, 1'($urandom), 1, W'({$urandom, $urandom}));
        cycle(1, 1'($urandom), 1, W'({$urandom, $urandom}));
        cycle(0, 0, 0, cb1);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_tile", 32'(rd_tile), 32'd0);
        chk("rst_last", 32'(rd_last), 32'd0);
        chk("rst_changed", 32'(rd_changed), 32'd0);
        got.delete();

        sweep(cb1);
        set_tab(cb1, 4'b1101);
        check_got("basic");

        for (int i = 0; i < 3; i++) cycle(0, 0, 1, cb1);
        cycle(0, 1, 0, cb1);
        for (int i = 0; i < 12; i++) cycle(0, 0, (i % 3 == 2), cb1);
        cycle(0, 0, 1, cb1);
        set_tab(cb1, 4'b0000);
        check_got("bp");

        sweep(cb2);
        set_tab(cb2, 4'b0100);
        check_got("chg");

        cb3 = W'({$urandom, $urandom});
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, cb2);
        cycle(0, 1, 1, cb2);
        cycle(0, 0, 0, cb3);
        cycle(0, 1, 1, cb3);
        cycle(0, 0, 1, cb3);
        cycle(0, 0, 1, cb3);
        cycle(0, 1, 1, cb3);
        cycle(0, 0, 1, cb3);
        chk("iso_busy_after", 32'(busy), 32'd0);
        cycle(0, 0, 1, cb3);
        chk("iso_single_sweep", 32'(rd_valid), 32'd0);
        set_tab(cb2, 4'b0000);
        check_got("iso");

        for (int i = 0; i < 3; i++) cycle(0, 0, 1, cb4);
        cycle(0, 1, 1, cb4);
        cycle(0, 0, 1, cb4);
        cycle(0, 0, 1, cb4);
        cycle(1, 0, 1, cb4);
        cycle(0, 0, 1, cb4);
        chk("rst_mid_valid", 32'(rd_valid), 32'd0);
        got.delete();
        sweep(cb4);
        set_tab(cb4, 4'b1101);
        check_got("rst_mid");

        cbr = W'({$urandom, $urandom});
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) cbr = W'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) cbr[NB +: NB] = cbr[0 +: NB];
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom), cbr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
